// File: rtl/neko_pkg.sv
// Shared constants and types for the writeback stage: load funct3 codes,
// default data/register widths and the port-arbitration state.
package neko_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic {
    OPEN  = 1'b0,
    FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/writeback_stage_if.sv
// Memory-stage -> writeback result handshake. The memory stage drives through
// the master modport; the writeback stage consumes through the slave modport.
interface writeback_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) ();

  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rd;
  logic              in_is_load;
  logic [2:0]        in_funct3;
  logic [1:0]        in_byte_off;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_load_word;

  modport master (
    output in_valid, in_rd, in_is_load, in_funct3, in_byte_off,
           in_alu_result, in_load_word,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rd, in_is_load, in_funct3, in_byte_off,
           in_alu_result, in_load_word,
    output in_ready
  );

endinterface

// File: rtl/writeback_stage_load_align.sv
// Combinational load formatter: picks the byte/half addressed by byte_off and
// sign- or zero-extends it according to funct3; unknown codes pass the word.
module load_align
  import neko_pkg::*;
#(
  parameter int DATA_W = neko_pkg::DATA_W
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        byte_off,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{byte_off, 3'b000} +: 8];
    half_sel = byte_off[1] ? word[31:16] : word[15:0];
    case (funct3)
      LB:      data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LH:      data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LW:      data = word;
      LBU:     data = {{(DATA_W-8){1'b0}}, byte_sel};
      LHU:     data = {{(DATA_W-16){1'b0}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: result FIFO plus shared register-bank port arbiter with
// starvation protection. Define WB_BYPASS_EN to add the pending-result bypass.
module writeback_stage
  import neko_pkg::*;
#(
  parameter int DATA_W     = neko_pkg::DATA_W,
  parameter int REG_AW     = neko_pkg::REG_AW,
  parameter int FIFO_DEPTH = 2,
  parameter int HOLD_MAX   = 2
) (
  input  logic              clk,
  input  logic              reset,
  writeback_stage_if.slave  mem,
  input  logic              rd_req_valid,
  input  logic [REG_AW-1:0] rd_req_sel,
  output logic              rd_grant,
  output logic              rf_write,
  output logic [REG_AW-1:0] rf_select,
  output logic [DATA_W-1:0] rf_dataIn,
  output logic              busy,
  output logic [31:0]       retired_count
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_AW-1:0] byp_sel,
  output logic              byp_hit,
  output logic [DATA_W-1:0] byp_data
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            fifo_q [FIFO_DEPTH];
  entry_t            fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [31:0]       retired_q, retired_d;
  arb_state_e        state_q, state_d;

  logic [DATA_W-1:0] load_data;
  entry_t            new_entry;
  entry_t            head_entry;
  logic              empty, enq, deq;

  load_align #(.DATA_W(DATA_W)) u_align (
    .funct3   (mem.in_funct3),
    .byte_off (mem.in_byte_off),
    .word     (mem.in_load_word),
    .data     (load_data)
  );

  assign empty         = (count_q == '0);
  assign mem.in_ready  = (count_q != CNT_W'(FIFO_DEPTH));
  assign enq           = mem.in_valid & mem.in_ready;
  assign busy          = ~empty;
  assign retired_count = retired_q;
  assign head_entry    = fifo_q[head_q];
  assign new_entry.rd   = mem.in_rd;
  assign new_entry.data = mem.in_is_load ? load_data : mem.in_alu_result;

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
    assign fifo_d[gi] = (enq && (tail_q == PTR_W'(gi))) ? new_entry : fifo_q[gi];
  end

  // x0 heads retire without the port, so decode keeps its grant that cycle.
  always_comb begin
    rd_grant  = rd_req_valid;
    rf_write  = 1'b0;
    rf_select = rd_req_sel;
    rf_dataIn = head_entry.data;
    deq       = 1'b0;
    hold_d    = hold_q;
    state_d   = state_q;
    if (!empty) begin
      if (head_entry.rd == '0) begin
        deq = 1'b1;
      end else if ((state_q == FORCE) || !rd_req_valid) begin
        rd_grant  = 1'b0;
        rf_write  = 1'b1;
        rf_select = head_entry.rd;
        deq       = 1'b1;
        hold_d    = '0;
        state_d   = OPEN;
      end else begin
        hold_d = hold_q + 1'b1;
        if (hold_d == HOLD_W'(HOLD_MAX)) state_d = FORCE;
      end
    end
  end

  always_comb begin
    head_d    = deq ? head_q + 1'b1 : head_q;
    tail_d    = enq ? tail_q + 1'b1 : tail_q;
    count_d   = count_q + CNT_W'(enq) - CNT_W'(deq);
    retired_d = retired_q + 32'(deq);
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      hold_q    <= '0;
      retired_q <= '0;
      state_q   <= OPEN;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      hold_q    <= hold_d;
      retired_q <= retired_d;
      state_q   <= state_d;
    end
  end

`ifdef WB_BYPASS_EN
  // Scan oldest to newest so the youngest matching entry wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    byp_hit  = 1'b0;
    byp_data = '0;
    idx      = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (byp_sel != '0) && (fifo_q[idx].rd == byp_sel)) begin
        byp_hit  = 1'b1;
        byp_data = fifo_q[idx].data;
      end
    end
  end
`endif

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Last CPU pipeline stage; sits directly upstream of the 16 x 32-bit register bank.
- Accepts retiring results from the memory stage over a valid/ready handshake. Aligns and sign-extends load data, buffers results in a small FIFO, and drives the register bank's write/select/dataIn.
- The register bank has a single shared select for read and write. This block therefore arbitrates that select against decode-stage read requests, with starvation protection.

Parameters:
- DATA_W, 32, register/data width
- REG_AW, 4, register index width (16 registers)
- FIFO_DEPTH, 2, pending-result entries; power of two, >= 2
- HOLD_MAX, 2, consecutive denied cycles before writeback forces the port

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  memory stage has a result
- in_ready  out  1  stage can accept (= FIFO not full)
- in_rd  in  REG_AW  destination register
- in_is_load  in  1  1 = take formatted load data, 0 = take in_alu_result
- in_funct3  in  3  load width/sign code
- in_byte_off  in  2  address[1:0] of the load
- in_alu_result  in  DATA_W  ALU result
- in_load_word  in  DATA_W  raw aligned memory word
- rd_req_valid  in  1  decode wants the bank's read port this cycle
- rd_req_sel  in  REG_AW  register decode wants to read
- rd_grant  out  1  decode owns the port this cycle
- rf_write  out  1  to bank write
- rf_select  out  REG_AW  to bank select
- rf_dataIn  out  DATA_W  to bank dataIn
- busy  out  1  FIFO non-empty
- retired_count  out  32  results dequeued since reset; wraps at 2^32

Behaviour:
- Reset: FIFO emptied and all pending entries dropped. retired_count=0, hold counter=0, rf_write=0, busy=0, in_ready=1. A reset mid-drain drops entries with no write issued.
- Enqueue:
  - Occurs when in_valid & in_ready at the edge.
  - Data is formatted before storage.
  - Full FIFO gives in_ready=0; there is no simultaneous enqueue+dequeue bypass when full.
- Load formatting (in_is_load=1):
  - 000 LB: byte selected by in_byte_off, sign-extended.
  - 001 LH: half selected by in_byte_off[1], sign-extended.
  - 010 LW: word unchanged.
  - 100 LBU: byte selected by in_byte_off, zero-extended.
  - 101 LHU: half selected by in_byte_off[1], zero-extended.
  - Other codes: word unchanged.
- Head entry rd==0 (x0):
  - Dequeued without rf_write and without needing the port; allowed even while decode holds the port.
  - Counts as retired.
- Head entry rd!=0, arbitration (combinational outputs):
  - State OPEN: if rd_req_valid, decode wins. rd_grant=1, rf_select=rd_req_sel, rf_write=0, hold counter increments when FIFO non-empty. Otherwise writeback wins: rf_write=1, rf_select=head rd, rf_dataIn=head data, rd_grant=0, entry dequeued at the edge.
  - OPEN -> FORCE when hold counter reaches HOLD_MAX.
  - State FORCE: writeback wins regardless of rd_req_valid (rd_grant=0). After the forced dequeue, hold counter clears and state returns to OPEN.
- Idle (FIFO empty): rf_write=0, rf_select=rd_req_sel, rd_grant=rd_req_valid.
- Latency: result accepted at edge N is written into the bank at edge N+1 when the FIFO was empty and the port is free.
- Ordering: strict FIFO. Writes to the same rd land in arrival order.
- retired_count increments by 1 on every dequeue, x0 included.

Optional Feature:
- Macro: WB_BYPASS_EN
- Defined:
  - Adds ports byp_sel in REG_AW, byp_hit out 1, byp_data out DATA_W.
  - byp_hit=1 when any valid FIFO entry has rd==byp_sel and byp_sel!=0.
  - byp_data = formatted data of the newest matching entry.
  - Lets decode read results not yet written into the bank.
- Undefined: ports and comparison logic are absent; decode must stall while busy.

Decomposition:
- Shared package neko_pkg: funct3 load constants (LB, LH, LW, LBU, LHU), REG_AW, DATA_W, arbitration-state enum (OPEN, FORCE).
- Sub-module: load_align, purely combinational (funct3, byte_off, word -> formatted data).
- FIFO and arbiter stay in writeback_stage.

Test Plan:
- LB, off=3, word 0x80FF_1234, rd=5, no reads -> next edge: rf_write=1, rf_select=5, rf_dataIn=0xFFFF_FF80.
- LHU, off=2, word 0xBEEF_0001, rd=7 -> rf_dataIn=0x0000_BEEF. Unknown funct3 011 -> word passed unchanged.
- ALU 0xDEAD_BEEF with rd=0, rd_req_valid=1 -> no rf_write, rd_grant stays 1, retired_count=1, busy=0 next cycle.
- Two entries enqueued, rd_req_valid held high:
  - in_ready=0 and rd_grant=1 for 2 cycles.
  - Third cycle: rd_grant=0, oldest entry written.
  - Pattern repeats for the second entry.
- Two entries pending, reset asserted one cycle -> next cycle: rf_write=0, busy=0, in_ready=1, retired_count=0; no write for dropped entries.
- WB_BYPASS_EN: entries rd=3 data 0x11 then rd=3 data 0x22 pending, byp_sel=3 -> byp_hit=1, byp_data=0x22. byp_sel=0 -> byp_hit=0.
